fifo_ctrl: RTL and testbench

Pointer and flag controller for the synchronous FIFO. It accepts write and read requests, gates them against full and empty, and advances wrap-extended read/write pointers. It drives the address and enable lines of the FIFO storage RAM and produces occupancy, empty, full, almost-empty and almost-full status plus sticky overflow and underflow errors. The almost thresholds are parameters; no thresholds are hard-coded.

---
 rtl/fifo_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fifo_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Pointer and flag controller for a synchronous FIFO. It accepts write and read
// requests and gates them against full and empty. It advances wrap-extended
// pointers, drives the storage RAM address/enable lines, and reports occupancy,
// status flags and sticky overflow/underflow errors.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   wr_req    in   producer write request
//   rd_req    in   consumer read request
//   clr       in   synchronous flush (empties FIFO, clears errors)
//   wr_en     out  RAM write strobe (accepted write)
//   rd_en     out  RAM read strobe (accepted read)
//   waddr     out  RAM write address [ADDR_W-1:0]
//   raddr     out  RAM read address  [ADDR_W-1:0]
//   rd_valid  out  RAM read data valid (rd_en delayed one cycle)
//   count     out  occupancy 0..DEPTH [ADDR_W:0]
//   empty     out  count == 0
//   full      out  count == DEPTH
//   ae_flag   out  count <= AE_THRESH
//   af_flag   out  count >= AF_THRESH
//   ovf       out  sticky: write requested while full
//   udf       out  sticky: read requested while empty
// -----------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AE_THRESH = 4,
  parameter int AF_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              clr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ae_flag,
  output logic              af_flag,
  output logic              ovf,
  output logic              udf
);

  // Thresholds reduced to the occupancy width so that every compare is
  // same-width. DEPTH itself needs the extra wrap bit.
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];

  // Registered state
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            ae_q, ae_d;
  logic            af_q, af_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            rd_valid_q, rd_valid_d;

  // Accept gating. It uses only registered flags, so a read at full cannot
  // free space for a write in the same cycle, and a write at empty cannot
  // fall through to a read.
  logic wr_acc;
  logic rd_acc;

  always_comb begin
    wr_acc = wr_req & ~full_q  & ~clr;
    rd_acc = rd_req & ~empty_q & ~clr;
  end

  // Next-state logic. The flags come from the next-state pointers, so they
  // update on the same edge as the pointers.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rd_valid_d = 1'b0;

    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
      rd_valid_d = 1'b0;
    end else begin
      wptr_d     = wptr_q + {{ADDR_W{1'b0}}, wr_acc};
      rptr_d     = rptr_q + {{ADDR_W{1'b0}}, rd_acc};
      // Errors look at the registered flags: a refused request is the event.
      ovf_d      = ovf_q | (wr_req & full_q);
      udf_d      = udf_q | (rd_req & empty_q);
      rd_valid_d = rd_acc;
    end

    // The modulo 2**(ADDR_W+1) subtraction gives the occupancy directly,
    // because both pointers carry a wrap bit.
    count_d = wptr_d - rptr_d;
    // Pointers fully equal means empty. Equal address bits with differing
    // wrap bits means full.
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]) &&
              (wptr_d[ADDR_W] != rptr_d[ADDR_W]);
    ae_d    = (count_d <= AE_C);
    af_d    = (count_d >= AF_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ae_q       <= 1'b1;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ae_q       <= ae_d;
      af_q       <= af_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Output mapping
  always_comb begin
    wr_en    = wr_acc;
    rd_en    = rd_acc;
    waddr    = wptr_q[ADDR_W-1:0];
    raddr    = rptr_q[ADDR_W-1:0];
    rd_valid = rd_valid_q;
    count    = count_q;
    empty    = empty_q;
    full     = full_q;
    ae_flag  = ae_q;
    af_flag  = af_q;
    ovf      = ovf_q;
    udf      = udf_q;
  end

  // Keep the occupancy register consistent with the depth bound.
  // The check is not part of the synthesized logic.
  logic unused_depth_ok;
  assign unused_depth_ok = (count_q <= DEPTH_C);

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
// Self-checking bench for fifo_ctrl. Directed phases follow the test plan.
// They are followed by a randomized phase. All of them are compared against an
// integer occupancy model of the FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AE     = 4;
  localparam int AF     = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_req, rd_req, clr;
  logic              wr_en, rd_en, rd_valid;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [ADDR_W:0]   count;
  logic              empty, full, ae_flag, af_flag, ovf, udf;

  fifo_ctrl #(.ADDR_W(ADDR_W), .AE_THRESH(AE), .AF_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req), .clr(clr),
    .wr_en(wr_en), .rd_en(rd_en), .waddr(waddr), .raddr(raddr),
    .rd_valid(rd_valid), .count(count), .empty(empty), .full(full),
    .ae_flag(ae_flag), .af_flag(af_flag), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Reference model: the occupancy plus the total number of writes and reads,
  // taken modulo the pointer range.
  int m_cnt, m_w, m_r;
  bit m_ovf, m_udf, m_rv;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_w = 0; m_r = 0; m_ovf = 0; m_udf = 0; m_rv = 0;
  endtask

  task automatic check_state(input string pfx);
    check({pfx, ".count"},    int'(count),    m_cnt);
    check({pfx, ".empty"},    int'(empty),    int'(m_cnt == 0));
    check({pfx, ".full"},     int'(full),     int'(m_cnt == DEPTH));
    check({pfx, ".ae"},       int'(ae_flag),  int'(m_cnt <= AE));
    check({pfx, ".af"},       int'(af_flag),  int'(m_cnt >= AF));
    check({pfx, ".ovf"},      int'(ovf),      int'(m_ovf));
    check({pfx, ".udf"},      int'(udf),      int'(m_udf));
    check({pfx, ".rd_valid"}, int'(rd_valid), int'(m_rv));
    check({pfx, ".waddr"},    int'(waddr),    m_w % DEPTH);
    check({pfx, ".raddr"},    int'(raddr),    m_r % DEPTH);
  endtask

  // One clock cycle of stimulus. The strobes are checked before the edge.
  // The registered state is checked after the edge.
  task automatic step(input bit w, input bit r, input bit c);
    bit exp_we, exp_re;
    @(negedge clk);
    wr_req = w; rd_req = r; clr = c;
    #1;
    exp_we = w && !c && (m_cnt != DEPTH);
    exp_re = r && !c && (m_cnt != 0);
    check("wr_en", int'(wr_en), int'(exp_we));
    check("rd_en", int'(rd_en), int'(exp_re));
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      if (w && m_cnt == DEPTH) m_ovf = 1;
      if (r && m_cnt == 0)     m_udf = 1;
      if (exp_we) begin m_w = (m_w + 1) % (2*DEPTH); m_cnt++; end
      if (exp_re) begin m_r = (m_r + 1) % (2*DEPTH); m_cnt--; end
      m_rv = exp_re;
    end
    #1;
    txn++;
    $display("txn %0d wr=%0b rd=%0b clr=%0b -> count=%0d e=%0b f=%0b ovf=%0b udf=%0b",
             txn, w, r, c, count, empty, full, ovf, udf);
    check_state("post");
  endtask

  initial begin
    rst_n = 1'b0; wr_req = 0; rd_req = 0; clr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;

    // Idle after reset
    repeat (2) step(0, 0, 0);

    // Fill with 16 writes, then one overflowing request
    repeat (DEPTH) step(1, 0, 0);
    check("fill.full", int'(full), 1);
    step(1, 0, 0);
    check("fill.ovf", int'(ovf), 1);

    // Drain 16 reads, then one underflowing request
    repeat (DEPTH) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    check("drain.udf", int'(udf), 1);

    // Occupancy 8, then 20 cycles of simultaneous read and write
    step(0, 0, 1);
    repeat (8) step(1, 0, 0);
    repeat (20) step(1, 1, 0);
    check("simul.count", int'(count), 8);

    // Both requests at empty, then both requests at full
    step(0, 0, 1);
    step(1, 1, 0);
    check("empty_both.count", int'(count), 1);
    repeat (DEPTH - 1) step(1, 0, 0);
    step(1, 1, 0);
    check("full_both.count", int'(count), DEPTH - 1);

    // Occupancy 10 with ovf set, then a clr pulse
    step(0, 0, 1);
    repeat (DEPTH) step(1, 0, 0);
    step(1, 0, 0);
    repeat (6) step(0, 1, 0);
    step(0, 0, 1);
    check("clr.count", int'(count), 0);

    // Asynchronous reset between clock edges
    repeat (5) step(1, 0, 0);
    step(0, 1, 0);
    @(negedge clk);
    wr_req = 0; rd_req = 0; clr = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 1500; i++) begin
      int ph;
      ph = i / 250;
      step(($urandom_range(99) < ((ph % 2 == 0) ? 70 : 30)),
           ($urandom_range(99) < ((ph % 2 == 0) ? 30 : 70)),
           ($urandom_range(99) < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
